equation_game_fsm: RTL

- Game-rules stage directly downstream of the collision controller.
- Consumes per-frame single hit pulses for numbers and operands, plus the level-sensitive monkey/water collision.
- Maintains the running equation value, the pending operator and the lives count, and runs the top-level game state machine.
- Feeds the score/HUD drawers and monkey respawn logic.

---
 rtl/equation_game_fsm.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/equation_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : equation_game_fsm
//  Purpose  : Game-rules stage after the collision controller. Tracks the
//             running equation value, the pending operator and the lives
//             count, and runs the IDLE/PLAY/DYING/WIN/OVER state machine.
//  Revision : 1.0 - initial release
// ============================================================================
module equation_game_fsm #(
  parameter int NUMBERS      = 3,
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 45
) (
  input  logic                   clk_i,
  input  logic                   resetN_i,
  input  logic                   startOfFrame_i,
  input  logic                   startGame_i,
  input  logic [NUMBERS-1:0]     numberHit_i,
  input  logic [NUMBERS*4-1:0]   numberValues_i,
  input  logic [1:0]             operandHit_i,
  input  logic                   waterCollision_i,
  input  logic [7:0]             targetValue_i,
  output logic [7:0]             accValue_o,
  output logic [1:0]             pendingOp_o,
  output logic [1:0]             lives_o,
  output logic [2:0]             gameState_o,
  output logic                   respawnPulse_o,
  output logic                   winPulse_o,
  output logic                   gameOver_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_WIN   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] c_OP_NONE = 2'b00;
  localparam logic [1:0] c_OP_ADD  = 2'b01;
  localparam logic [1:0] c_OP_SUB  = 2'b10;

  localparam logic [1:0] c_LIVES_RST = LIVES_INIT[1:0];

  // Frame counter runs 0..DEATH_FRAMES-1 while dying.
  localparam int               c_CNT_W    = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEATH_FRAMES - 1);

  state_t               state_q, state_d;
  logic [7:0]           acc_q, acc_d;
  logic [1:0]           op_q, op_d;
  logic [1:0]           lives_q, lives_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 taken_q, taken_d;
  logic                 respawn_q, respawn_d;
  logic                 win_q, win_d;
  logic                 over_q, over_d;

  logic                 hit_found;
  logic [3:0]           hit_val;
  logic [8:0]           sum9;
  logic [7:0]           add_sat;
  logic [7:0]           sub_flr;

  // Pick the lowest-indexed number hit; higher simultaneous hits are dropped.
  always_comb begin
    hit_found = 1'b0;
    hit_val   = 4'd0;
    for (int i = 0; i < NUMBERS; i++) begin
      if (numberHit_i[i] && !hit_found) begin
        hit_found = 1'b1;
        hit_val   = numberValues_i[i*4 +: 4];
      end
    end
  end

  // Saturating add and flooring subtract of the selected digit.
  always_comb begin
    sum9    = {1'b0, acc_q} + {5'd0, hit_val};
    add_sat = sum9[8] ? 8'hFF : sum9[7:0];
    sub_flr = ({4'd0, hit_val} > acc_q) ? 8'd0 : (acc_q - {4'd0, hit_val});
  end

  // Next-state and next-output logic of the game state machine.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    respawn_d = 1'b0;
    win_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_d   = 8'd0;
        op_d    = c_OP_NONE;
        lives_d = c_LIVES_RST;
        taken_d = 1'b0;
        cnt_d   = '0;
        if (startGame_i) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (waterCollision_i) begin
          // Leaving PLAY immediately makes this a single decrement.
          state_d = ST_DYING;
          lives_d = lives_q - 2'd1;
        end else begin
          if (hit_found) begin
            case (op_q)
              c_OP_ADD: acc_d = add_sat;
              c_OP_SUB: acc_d = sub_flr;
              default:  acc_d = {4'd0, hit_val};
            endcase
            op_d    = c_OP_NONE;
            taken_d = 1'b1;
          end
          // Operand latched after the number consumed the old operator.
          if (operandHit_i[0])      op_d = c_OP_ADD;
          else if (operandHit_i[1]) op_d = c_OP_SUB;
          // Win uses registered values, so it lags the matching update by a cycle.
          if (taken_q && (acc_q == targetValue_i)) begin
            state_d = ST_WIN;
            win_d   = 1'b1;
          end
        end
      end

      ST_DYING: begin
        if (startOfFrame_i) begin
          if (cnt_q == c_CNT_LAST) begin
            cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d   = ST_PLAY;
              respawn_d = 1'b1;
              acc_d     = 8'd0;
              op_d      = c_OP_NONE;
              taken_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WIN: begin
        if (startGame_i) begin
          state_d = ST_PLAY;
          acc_d   = 8'd0;
          op_d    = c_OP_NONE;
          taken_d = 1'b0;
        end
      end

      ST_OVER: begin
        if (startGame_i) begin
          state_d = ST_IDLE;
          lives_d = c_LIVES_RST;
          acc_d   = 8'd0;
          op_d    = c_OP_NONE;
          taken_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    over_d = (state_d == ST_OVER);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk_i or negedge resetN_i) begin
    if (!resetN_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= 8'd0;
      op_q      <= c_OP_NONE;
      lives_q   <= c_LIVES_RST;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      respawn_q <= 1'b0;
      win_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      respawn_q <= respawn_d;
      win_q     <= win_d;
      over_q    <= over_d;
    end
  end

  assign accValue_o     = acc_q;
  assign pendingOp_o    = op_q;
  assign lives_o        = lives_q;
  assign gameState_o    = state_q;
  assign respawnPulse_o = respawn_q;
  assign winPulse_o     = win_q;
  assign gameOver_o     = over_q;

endmodule
`default_nettype wire
